// File: rtl/pwm_sample_modulator.sv
// PWM consumer of the channel level stream: double-buffers 9-bit levels
// (shadow -> active at period wrap) and drives a registered PWM pin.
module pwm_sample_modulator #(
    parameter int unsigned PERIOD = 512,
    parameter int unsigned CNT_W  = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [8:0] i_sample,
    input  logic       i_sample_valid,
    output logic       o_sample_ready,
    output logic       o_pwm,
    output logic       o_period_start,
    output logic       o_underrun
);

    localparam int unsigned SMP_W = 9;
    localparam int unsigned LVL_W = SMP_W + 1;
    // Compare wide enough that levels >= PERIOD saturate instead of wrapping.
    localparam int unsigned CMP_W = (CNT_W > LVL_W) ? CNT_W : LVL_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SMP_W-1:0] shadow;
    logic [SMP_W-1:0] shadow_nxt;
    logic             shadow_full;
    logic             shadow_full_nxt;
    logic [LVL_W-1:0] active;
    logic [LVL_W-1:0] active_nxt;
    logic             wrap;
    logic             accept;
    logic             pwm_nxt;
    logic             underrun_nxt;

    assign o_sample_ready = !shadow_full;

    // Next-state for counter, shadow buffer and active level.
    always_comb begin
        cnt_nxt         = cnt + CNT_W'(1);
        shadow_nxt      = shadow;
        shadow_full_nxt = shadow_full;
        active_nxt      = active;
        underrun_nxt    = 1'b0;
        wrap            = (cnt == LAST);
        accept          = i_sample_valid && !shadow_full;

        if (wrap) begin
            cnt_nxt = '0;
            if (shadow_full) begin
                active_nxt      = {1'b0, shadow};
                shadow_full_nxt = 1'b0;
            end else begin
                underrun_nxt = 1'b1;
            end
        end

        // Accept only happens with shadow empty, so it never collides with the transfer.
        if (accept) begin
            shadow_nxt      = i_sample;
            shadow_full_nxt = 1'b1;
        end

        pwm_nxt = (CMP_W'(cnt_nxt) < CMP_W'(active_nxt));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt            <= '0;
            shadow         <= '0;
            shadow_full    <= 1'b0;
            active         <= '0;
            o_pwm          <= 1'b0;
            o_period_start <= 1'b0;
            o_underrun     <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            shadow         <= shadow_nxt;
            shadow_full    <= shadow_full_nxt;
            active         <= active_nxt;
            o_pwm          <= pwm_nxt;
            o_period_start <= (cnt_nxt == '0);
            o_underrun     <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_sample_modulator.sv
// Randomised bench for pwm_sample_modulator against a level/position reference model.
module tb_pwm_sample_modulator;

    localparam int P = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] sample;
    logic       valid;
    logic       ready;
    logic       pwm;
    logic       period_start;
    logic       underrun;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within period, level in force, one pending sample.
    int m_pos     = 0;
    int m_level   = 0;
    bit m_pend    = 0;
    int m_pend_v  = 0;
    bit e_pwm     = 0;
    bit e_ps      = 0;
    bit e_ur      = 0;
    // Per-period high-time tracking.
    bit trk_ok    = 0;
    int trk_exp   = 0;
    int hi_cnt    = 0;

    pwm_sample_modulator #(.PERIOD(P), .CNT_W(5)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sample       (sample),
        .i_sample_valid (valid),
        .o_sample_ready (ready),
        .o_pwm          (pwm),
        .o_period_start (period_start),
        .o_underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input int s);
        bit wrap;
        if (r) begin
            m_pos = 0; m_level = 0; m_pend = 0;
            e_pwm = 0; e_ps = 0; e_ur = 0;
            trk_ok = 0;
            return;
        end
        wrap = (m_pos == P - 1);
        e_ur = wrap && !m_pend;
        if (wrap && m_pend) begin
            m_level = m_pend_v;
            m_pend  = 0;
        end else if (v && !m_pend) begin
            m_pend   = 1;
            m_pend_v = s;
        end
        m_pos = (m_pos + 1) % P;
        e_pwm = (m_pos < m_level);
        e_ps  = (m_pos == 0);
    endtask

    // One clock: check ready, let the edge happen, update model, check outputs.
    task automatic step();
        bit r, v;
        int s;
        r = rst; v = valid; s = int'(sample);
        check("ready", ready, !m_pend);
        @(posedge clk);
        model_edge(r, v, s);
        #1;
        check("pwm", pwm, e_pwm);
        check("period_start", period_start, e_ps);
        check("underrun", underrun, e_ur);
        if (!r && e_ps) begin
            if (trk_ok) check("high_time", hi_cnt, trk_exp);
            trk_exp = (m_level < P) ? m_level : P;
            hi_cnt  = 0;
            trk_ok  = 1;
        end
        if (trk_ok && pwm === 1'b1) hi_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a sample and hold it until taken; valid is left high for the caller.
    task automatic send_hold(input int val);
        bit taken;
        int k;
        valid = 1'b1;
        sample = 9'(val);
        k = 0;
        do begin
            taken = !m_pend;
            step();
            k++;
        end while (!taken && k < 100);
        if (!taken) check("accept_timeout", 0, 1);
    endtask

    initial begin
        int k;
        rst = 1'b1; valid = 1'b0; sample = '0;
        run(2);
        rst = 1'b0;
        check("reset_pwm", pwm, 0);
        check("reset_ready", ready, 1);

        // Idle: pin low, underrun every period.
        run(40);

        // Single one-cycle sample of 5.
        valid = 1'b1; sample = 9'd5;
        step();
        valid = 1'b0;
        run(50);

        // Back-to-back held samples 3 then 12.
        send_hold(3);
        send_hold(12);
        valid = 1'b0;
        run(40);

        // Boundary levels.
        send_hold(0);   valid = 1'b0; run(36);
        send_hold(16);  valid = 1'b0; run(36);
        send_hold(300); valid = 1'b0; run(36);

        // Valid exactly on the wrap cycle with shadow empty.
        send_hold(4); valid = 1'b0;
        run(20);
        k = 0;
        while (m_pos != P - 1 && k < 40) begin step(); k++; end
        valid = 1'b1; sample = 9'd10;
        step();
        valid = 1'b0;
        check("wrap_underrun", underrun, 1);
        run(40);

        // Reset mid-period with level 9 active and a sample pending.
        send_hold(9); valid = 1'b0;
        k = 0;
        while (!(m_level == 9 && m_pos == 6 && !m_pend) && k < 60) begin step(); k++; end
        check("reach_pos6", m_pos, 6);
        valid = 1'b1; sample = 9'd2;
        step();
        valid = 1'b0;
        check("pend_before_reset", ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_reset_pwm", pwm, 0);
        check("mid_reset_ready", ready, 1);
        run(40);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            valid  = ($urandom_range(0, 7) == 0);
            sample = 9'($urandom_range(0, 511));
            rst    = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; valid = 1'b0;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
